sha1_core: RTL

SHA1_CORE -- requirements
Module: sha1_core

---
 rtl/sha1_pkg.sv | 36 +++
 rtl/sha1shift.sv | 31 +++
 rtl/sha1_core.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sha1_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha1_pkg
//  Purpose  : SHA-1 initial hash values, round constants and FSM encoding.
//  Revision : 1.0
// ============================================================================
package sha1_pkg;

    localparam logic [31:0] C_IV_H0 = 32'h67452301;
    localparam logic [31:0] C_IV_H1 = 32'hEFCDAB89;
    localparam logic [31:0] C_IV_H2 = 32'h98BADCFE;
    localparam logic [31:0] C_IV_H3 = 32'h10325476;
    localparam logic [31:0] C_IV_H4 = 32'hC3D2E1F0;

    localparam logic [31:0] C_K0 = 32'h5A827999;
    localparam logic [31:0] C_K1 = 32'h6ED9EBA1;
    localparam logic [31:0] C_K2 = 32'h8F1BBCDC;
    localparam logic [31:0] C_K3 = 32'hCA62C1D6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2,
        S_FINAL  = 2'd3
    } state_t;

    function automatic logic [31:0] rol5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] rol30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha1shift.sv
`default_nettype none
// ============================================================================
//  Module   : sha1shift
//  Purpose  : 16-word SHA-1 message schedule; out is the most recent word.
//  Revision : 1.0
// ============================================================================
module sha1shift (
    input  logic        clk,
    input  logic        en,
    input  logic [31:0] in,
    output logic [31:0] out
);

    // r_w[15] holds W[t-1], r_w[0] holds W[t-16] when W[t] is being formed
    logic [31:0] r_w [16];
    logic [31:0] w_mix;
    logic [31:0] w_fb;

    assign w_mix = r_w[13] ^ r_w[8] ^ r_w[2] ^ r_w[0];
    assign w_fb  = {w_mix[30:0], w_mix[31]};
    assign out   = r_w[15];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 15; i++) begin
            r_w[i] <= r_w[i+1];
        end
        r_w[15] <= en ? in : w_fb;
    end

endmodule
`default_nettype wire

// File: rtl/sha1_core.sv
`default_nettype none
// ============================================================================
//  Module   : sha1_core
//  Purpose  : Word-serial SHA-1 block compressor, one round per clock.
//  Revision : 1.0
// ============================================================================
module sha1_core
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic         in_valid,
    input  logic [31:0]  in,
    output logic         in_ready,
    output logic [159:0] digest,
    output logic         digest_valid,
    output logic         err
);

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_cnt;
    logic [31:0] r_a, r_b, r_c, r_d, r_e;
    logic [31:0] r_h0, r_h1, r_h2, r_h3, r_h4;
    logic        r_dv;
    logic        r_err;

    logic        w_en;
    logic [31:0] w_w;
    logic [31:0] w_f;
    logic [31:0] w_k;
    logic [31:0] w_t;

    assign w_en = ((r_state == S_IDLE) && in_valid) || (r_state == S_LOAD);

    sha1shift u_sched (
        .clk (clk),
        .en  (w_en),
        .in  (in),
        .out (w_w)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (in_valid) w_next = S_LOAD;
            S_LOAD: begin
                if (!in_valid)            w_next = S_IDLE;
                else if (r_cnt == 7'd15)  w_next = S_EXPAND;
            end
            S_EXPAND: if (r_cnt == 7'd80) w_next = S_FINAL;
            S_FINAL:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // r_cnt equals k in cycle Ck, so the round being computed is r_cnt-1
    always_comb begin
        w_f = r_b ^ r_c ^ r_d;
        w_k = C_K3;
        if (r_cnt <= 7'd20) begin
            w_f = (r_b & r_c) | (~r_b & r_d);
            w_k = C_K0;
        end else if (r_cnt <= 7'd40) begin
            w_k = C_K1;
        end else if (r_cnt <= 7'd60) begin
            w_f = (r_b & r_c) | (r_b & r_d) | (r_c & r_d);
            w_k = C_K2;
        end
    end

    assign w_t = rol5(r_a) + w_f + r_e + w_k + w_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_dv    <= 1'b0;
            r_err   <= 1'b0;
            r_h0    <= C_IV_H0;
            r_h1    <= C_IV_H1;
            r_h2    <= C_IV_H2;
            r_h3    <= C_IV_H3;
            r_h4    <= C_IV_H4;
        end else begin
            r_state <= w_next;
            r_dv    <= (r_state == S_FINAL);
            r_err   <= (r_state == S_LOAD) && !in_valid;
            if ((r_state == S_IDLE) && init) begin
                r_h0 <= C_IV_H0;
                r_h1 <= C_IV_H1;
                r_h2 <= C_IV_H2;
                r_h3 <= C_IV_H3;
                r_h4 <= C_IV_H4;
            end else if (r_state == S_FINAL) begin
                r_h0 <= r_h0 + r_a;
                r_h1 <= r_h1 + r_b;
                r_h2 <= r_h2 + r_c;
                r_h3 <= r_h3 + r_d;
                r_h4 <= r_h4 + r_e;
            end
        end
    end

    // Working registers and counter are don't-care in IDLE; reloaded every idle cycle
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            r_cnt <= 7'd1;
            if (init) begin
                r_a <= C_IV_H0;
                r_b <= C_IV_H1;
                r_c <= C_IV_H2;
                r_d <= C_IV_H3;
                r_e <= C_IV_H4;
            end else begin
                r_a <= r_h0;
                r_b <= r_h1;
                r_c <= r_h2;
                r_d <= r_h3;
                r_e <= r_h4;
            end
        end else if ((r_state == S_LOAD) || (r_state == S_EXPAND)) begin
            r_cnt <= r_cnt + 7'd1;
            r_a   <= w_t;
            r_b   <= r_a;
            r_c   <= rol30(r_b);
            r_d   <= r_c;
            r_e   <= r_d;
        end
    end

    assign in_ready     = (r_state == S_IDLE);
    assign digest       = {r_h0, r_h1, r_h2, r_h3, r_h4};
    assign digest_valid = r_dv;
    assign err          = r_err;

endmodule
`default_nettype wire
